// File: rtl/pingpong_pkg.sv
// Shared types and helpers for the ping-pong frame buffer.
package pingpong_pkg;

  typedef logic bank_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Output lane slot for raw lane k; swap puts lane 0 at the top.
  function automatic int lane_slot(input int k, input int ratio,
                                   input bit swap);
    return swap ? (ratio - 1 - k) : k;
  endfunction

endpackage

// File: rtl/pingpong_frame_buf_dpram.sv
// Mixed-width dual-port RAM: narrow write port, wide registered read.
module mixed_width_dpram
  import pingpong_pkg::*;
#(
  parameter int WR_W  = 8,
  parameter int RATIO = 4,
  parameter int WAW   = 10,
  parameter int RAW   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [WAW-1:0]        waddr,
  input  logic [WR_W-1:0]       wdata,
  input  logic                  re,
  input  logic [RAW-1:0]        raddr,
  output logic [WR_W*RATIO-1:0] q
);

  logic [WAW-1:0] wlane;
  logic [RAW-1:0] wword;

  assign wlane = waddr % WAW'(RATIO);
  assign wword = RAW'(waddr / WAW'(RATIO));

  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    logic [WR_W-1:0] mem [0:(1<<RAW)-1];
    logic [WR_W-1:0] q_l;

    always_ff @(posedge clk) begin
      if (we && wlane == WAW'(k)) mem[wword] <= wdata;
    end

    always_ff @(posedge clk) begin
      if (rst) q_l <= '0;
      else if (re) q_l <= mem[raddr];
    end

    assign q[k*WR_W +: WR_W] = q_l;
  end

endmodule

// File: rtl/pingpong_frame_buf.sv
// Double-buffered frame store, narrow writes / wide reads.
// Define PINGPONG_LANE_SWAP_EN for big-endian read lane order.
module pingpong_frame_buf
  import pingpong_pkg::*;
#(
  parameter int WR_W     = 8,
  parameter int RATIO    = 4,
  parameter int WR_DEPTH = 512,
  parameter int CNT_W    = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [addr_w(WR_DEPTH)-1:0]       wr_addr,
  input  logic [WR_W-1:0]                   wr_data,
  input  logic                              wr_en,
  input  logic                              wr_done,
  output logic                              cur_wr_buf,
  input  logic [addr_w(WR_DEPTH/RATIO)-1:0] rd_addr,
  input  logic                              rd_en,
  output logic [WR_W*RATIO-1:0]             rd_data,
  output logic                              rd_valid,
  output logic                              rd_avail,
  input  logic                              rd_done,
  output logic                              overrun,
  output logic [CNT_W-1:0]                  overrun_cnt
);

  localparam int RD_W  = WR_W * RATIO;
  localparam int WR_AW = addr_w(WR_DEPTH);
  localparam int RD_AW = addr_w(WR_DEPTH / RATIO);
`ifdef PINGPONG_LANE_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  bank_t      wb, rb, wb_nxt, rb_nxt;
  logic [1:0] full, full_rel, full_nxt;
  logic       accept;
  logic       re;
  logic [RD_W-1:0] q;

  // Reader release is applied before the hand-off test.
  always_comb begin
    full_rel = full;
    if (rd_done && rd_avail) full_rel[rb] = 1'b0;
  end

  assign accept = wr_done && !full_rel[~wb];

  always_comb begin
    full_nxt = full_rel;
    wb_nxt   = wb;
    rb_nxt   = rb;
    if (accept) begin
      full_nxt[wb] = 1'b1;
      rb_nxt       = wb;
      wb_nxt       = ~wb;
    end
  end

  assign re = rd_en && rd_avail;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb          <= 1'b0;
      rb          <= 1'b1;
      full        <= '0;
      rd_avail    <= 1'b0;
      rd_valid    <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      wb       <= wb_nxt;
      rb       <= rb_nxt;
      full     <= full_nxt;
      rd_avail <= full_nxt[rb_nxt];
      rd_valid <= re;
      overrun  <= wr_done && !accept;
      if (wr_done && !accept && overrun_cnt != '1)
        overrun_cnt <= overrun_cnt + CNT_W'(1);
    end
  end

  assign cur_wr_buf = wb;

  mixed_width_dpram #(
    .WR_W  (WR_W),
    .RATIO (RATIO),
    .WAW   (WR_AW + 1),
    .RAW   (RD_AW + 1)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr ({wb, wr_addr}),
    .wdata (wr_data),
    .re    (re),
    .raddr ({rb, rd_addr}),
    .q     (q)
  );

  for (genvar k = 0; k < RATIO; k++) begin : g_map
    assign rd_data[lane_slot(k, RATIO, SWAP)*WR_W +: WR_W] =
      q[k*WR_W +: WR_W];
  end

endmodule

// File: doc/pingpong_frame_buf.md
Name: pingpong_frame_buf

Overview:
Parametrised double-buffered frame store with narrow writes and wide reads, the next generation of the fixed 8-in/32-out ping-pong buffer.
- Writer (deframer side) fills one bank while the reader (host/DMA side) drains the other.
- Adds per-bank ownership handshake, overrun detection with a saturating counter, read-valid pipelining, and parametrised width/ratio/depth.

Parameters:
WR_W, 8, write data width in bits
RATIO, 4, read lanes per read word; read width RD_W = WR_W*RATIO
WR_DEPTH, 512, write words per bank (power of two, multiple of RATIO)
CNT_W, 8, overrun counter width

Ports:
clk  in  1  sole clock
rst  in  1  synchronous active-high reset
wr_addr  in  clog2(WR_DEPTH)  write address within the current write bank
wr_data  in  WR_W  write data
wr_en  in  1  write strobe
wr_done  in  1  one-cycle pulse: frame complete, request bank hand-off
cur_wr_buf  out  1  bank currently owned by writer
rd_addr  in  clog2(WR_DEPTH/RATIO)  read word address within the read bank
rd_en  in  1  read request
rd_data  out  RD_W  read data, one cycle after rd_en
rd_valid  out  1  qualifies rd_data
rd_avail  out  1  a full bank is held for the reader
rd_done  in  1  one-cycle pulse: reader releases its bank
overrun  out  1  one-cycle pulse: wr_done refused
overrun_cnt  out  CNT_W  saturating count of refused hand-offs

Behaviour:
- State: wb (write bank), rb (read bank), full[1:0]. Reset: wb=0, rb=1, full=0, rd_avail=0, rd_valid=0, rd_data=0, overrun=0, overrun_cnt=0. RAM contents are not cleared.
- Writes: wr_en writes wr_data at wr_addr of bank wb, every cycle, regardless of the full flags.
- Hand-off: on wr_done with full[~wb]=0 (after same-cycle rd_done is applied): full[wb]<=1, rb<=wb, wb<=~wb.
- Refusal: on wr_done with full[~wb]=1: overrun<=1 for one cycle, overrun_cnt increments and saturates at all-ones. wb is unchanged, so the next frame overwrites the current one.
- Simultaneous rd_done and wr_done: rd_done clears full[rb] first, so the hand-off succeeds with no overrun.
- rd_done with rd_avail=0 is ignored.
- rd_avail = full[rb], registered.
- Reads: rd_en at cycle N reads word rd_addr of bank rb; rd_data and rd_valid are valid at N+1. rd_valid = rd_en & rd_avail, sampled at N. rd_data holds its value when rd_valid=0.
- Lane mapping: write address a lands in read word a/RATIO, lane a%RATIO. Raw lane k occupies bits [k*WR_W +: WR_W].
- Reset mid-frame: partial frame discarded, both banks freed, any read in flight yields rd_valid=0.

Optional Feature:
PINGPONG_LANE_SWAP_EN
- Defined: rd_data lanes are reversed, so lane 0 (lowest write address) appears in the most-significant WR_W bits (big-endian word). This matches the existing 8/32 buffer.
- Undefined: raw little-endian lane order.
- Latency is identical either way.

Decomposition:
- Shared package pingpong_pkg: bank-index typedef, clog2-derived address widths, lane-index helper.
- One sub-module: mixed_width_dpram (WR_W write port, RD_W read port, registered read, per-bank instance or bank bit as MSB of address).
- Control (wb/rb/full, overrun) stays in the top level.

Test Plan:
- Reset, then write bytes 0x00..0x07 at addresses 0..7 into bank 0 and pulse wr_done -> cur_wr_buf=1, rd_avail=1 one cycle later. rd_en with rd_addr=1 -> rd_valid with rd_data=0x04050607 (swap on) or 0x07060504 (swap off).
- Fill bank 0 + wr_done, fill bank 1 + wr_done without rd_done -> overrun pulses once, overrun_cnt=1, cur_wr_buf stays 1, rd_avail stays 1.
- Hold reader blocked and issue 260 refused wr_done pulses -> overrun_cnt saturates at 255 (CNT_W=8).
- With bank 0 held by reader, pulse rd_done and wr_done in the same cycle -> no overrun, rb=1, rd_avail=1, cur_wr_buf=0.
- rd_en while rd_avail=0 -> rd_valid=0 and rd_data unchanged. rd_done while rd_avail=0 -> no state change.
- Assert rst mid-frame after 3 writes -> all flags and outputs at reset values next cycle, cur_wr_buf=0, overrun_cnt=0.
